// File: rtl/tiny_pll_pkg.sv
// Shared Tiny-PLL package: period lock detector state encoding and default parameters.
package tiny_pll_pkg;

  typedef enum logic [1:0] {
    PLD_IDLE    = 2'd0,
    PLD_MEASURE = 2'd1,
    PLD_LOCKED  = 2'd2
  } pld_state_e;

  localparam int unsigned PLD_EXP_PERIOD_DEF = 4;
  localparam int unsigned PLD_TOL_DEF        = 0;
  localparam int unsigned PLD_LOCK_COUNT_DEF = 4;
  localparam int unsigned PLD_TIMEOUT_DEF    = 16;
  localparam int unsigned PLD_CNT_W_DEF      = 16;

endpackage

// File: rtl/pld_edge_detect.sv
// Rising-edge detector for the feedback clock; PLD_SYNC_EN inserts a 2-flop synchronizer
// ahead of the edge register for sig_in asynchronous to clk_in.
module pld_edge_detect (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic sig_s;
  logic sig_d;

`ifdef PLD_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], sig_in};
    end
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = sig_in;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_d;

endmodule

// File: rtl/period_lock_detector.sv
// Measures the sig_in period in clk_in cycles, flags fast/slow/missing edges and asserts locked
// after LOCK_COUNT consecutive in-tolerance periods. PLD_SYNC_EN enables input synchronization.
module period_lock_detector
  import tiny_pll_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = PLD_EXP_PERIOD_DEF,
  parameter int unsigned TOL        = PLD_TOL_DEF,
  parameter int unsigned LOCK_COUNT = PLD_LOCK_COUNT_DEF,
  parameter int unsigned TIMEOUT    = PLD_TIMEOUT_DEF,
  parameter int unsigned CNT_W      = PLD_CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             fast_err,
  output logic             slow_err
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  // Lower bound saturates at zero when TOL exceeds EXP_PERIOD.
  localparam int unsigned LoInt = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
  localparam int unsigned HiInt = EXP_PERIOD + TOL;

  localparam logic [CNT_W-1:0] LoBound    = CNT_W'(LoInt);
  localparam logic [CNT_W-1:0] HiBound    = CNT_W'(HiInt);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    LockCnt    = MW'(LOCK_COUNT);

  pld_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_inc;
  logic             rise;
  logic             too_fast;
  logic             in_tol;

  pld_edge_detect u_edge (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise)
  );

  assign too_fast  = cnt < LoBound;
  assign in_tol    = !too_fast && (cnt <= HiBound);
  assign match_inc = (match_cnt == LockCnt) ? match_cnt : match_cnt + MW'(1);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state        <= PLD_IDLE;
      cnt          <= '0;
      match_cnt    <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fast_err     <= 1'b0;
      slow_err     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      fast_err     <= 1'b0;
      slow_err     <= 1'b0;
      unique case (state)
        PLD_IDLE: begin
          if (rise) begin
            cnt   <= CNT_W'(1);
            state <= PLD_MEASURE;
          end
        end
        PLD_MEASURE, PLD_LOCKED: begin
          // A rise coinciding with the timeout count is evaluated as a normal period.
          if (rise) begin
            period_out   <= cnt;
            period_valid <= 1'b1;
            cnt          <= CNT_W'(1);
            if (in_tol) begin
              match_cnt <= match_inc;
              if (match_inc == LockCnt) begin
                locked <= 1'b1;
                state  <= PLD_LOCKED;
              end
            end else begin
              match_cnt <= '0;
              locked    <= 1'b0;
              fast_err  <= too_fast;
              slow_err  <= !too_fast;
              state     <= PLD_MEASURE;
            end
          end else if (cnt == TimeoutCnt) begin
            slow_err  <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
            cnt       <= '0;
            state     <= PLD_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= PLD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_lock_detector.sv
// Directed self-checking bench for period_lock_detector (TOL=0 and TOL=1 instances).
module tb_period_lock_detector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_n2 = 1'b0;
  logic        sig_in = 1'b0;
  logic        sig_in2 = 1'b0;
  logic [15:0] period_out, period_out2;
  logic        period_valid, period_valid2;
  logic        locked, locked2;
  logic        fast_err, fast_err2;
  logic        slow_err, slow_err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  period_lock_detector #(
    .EXP_PERIOD (4),
    .TOL        (0),
    .LOCK_COUNT (4),
    .TIMEOUT    (16),
    .CNT_W      (16)
  ) dut (
    .clk_in       (clk),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .fast_err     (fast_err),
    .slow_err     (slow_err)
  );

  period_lock_detector #(
    .EXP_PERIOD (4),
    .TOL        (1),
    .LOCK_COUNT (4),
    .TIMEOUT    (16),
    .CNT_W      (16)
  ) dut_tol (
    .clk_in       (clk),
    .rst_n        (rst_n2),
    .sig_in       (sig_in2),
    .period_out   (period_out2),
    .period_valid (period_valid2),
    .locked       (locked2),
    .fast_err     (fast_err2),
    .slow_err     (slow_err2)
  );

  task automatic cyc(input logic v);
    sig_in  = v;
    sig_in2 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic rise_edge();
    cyc(1'b1);
  endtask

  // Next rise lands n cycles after the previous one.
  task automatic gap(input int n);
    for (int i = 0; i < n - 1; i++) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    checks++;
    if (period_out !== 16'd0 || period_valid !== 1'b0 || locked !== 1'b0 ||
        fast_err !== 1'b0 || slow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: po=%0d pv=%b lk=%b fe=%b se=%b, want all 0",
               period_out, period_valid, locked, fast_err, slow_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    rise_edge();
    checks++;
    if (period_valid !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_first_edge: pv=%b lk=%b, want 0 0", period_valid, locked);
    end
    for (int i = 1; i <= 4; i++) begin
      gap(4);
      checks++;
      if (period_valid !== 1'b1 || period_out !== 16'd4 || fast_err !== 1'b0 ||
          slow_err !== 1'b0 || locked !== (i == 4)) begin
        errors++;
        $display("FAIL lock_period%0d: pv=%b po=%0d fe=%b se=%b lk=%b, want 1 4 0 0 %b",
                 i, period_valid, period_out, fast_err, slow_err, locked, (i == 4));
      end
    end
  endtask

  task automatic test_fast();
    gap(3);
    checks++;
    if (period_valid !== 1'b1 || period_out !== 16'd3 || fast_err !== 1'b1 ||
        slow_err !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL fast: pv=%b po=%0d fe=%b se=%b lk=%b, want 1 3 1 0 0",
               period_valid, period_out, fast_err, slow_err, locked);
    end
    cyc(1'b0);
    checks++;
    if (fast_err !== 1'b0 || period_valid !== 1'b0) begin
      errors++;
      $display("FAIL fast_pulse_width: fe=%b pv=%b, want 0 0", fast_err, period_valid);
    end
    gap(3);
    for (int i = 2; i <= 4; i++) gap(4);
    checks++;
    if (locked !== 1'b1 || period_out !== 16'd4 || fast_err !== 1'b0) begin
      errors++;
      $display("FAIL fast_relock: lk=%b po=%0d fe=%b, want 1 4 0", locked, period_out, fast_err);
    end
  endtask

  task automatic test_slow();
    gap(6);
    checks++;
    if (period_valid !== 1'b1 || period_out !== 16'd6 || slow_err !== 1'b1 ||
        fast_err !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL slow: pv=%b po=%0d se=%b fe=%b lk=%b, want 1 6 1 0 0",
               period_valid, period_out, slow_err, fast_err, locked);
    end
    for (int i = 1; i <= 4; i++) gap(4);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL slow_relock: lk=%b, want 1", locked);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 15; i++) cyc(1'b0);
    checks++;
    if (slow_err !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: se=%b lk=%b, want 0 1", slow_err, locked);
    end
    cyc(1'b0);
    checks++;
    if (slow_err !== 1'b1 || locked !== 1'b0 || period_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout: se=%b lk=%b pv=%b, want 1 0 0", slow_err, locked, period_valid);
    end
    cyc(1'b0);
    rise_edge();
    checks++;
    if (period_valid !== 1'b0 || slow_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_restart_idle: pv=%b se=%b, want 0 0", period_valid, slow_err);
    end
    gap(4);
    checks++;
    if (period_valid !== 1'b1 || period_out !== 16'd4 || locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout_restart: pv=%b po=%0d lk=%b, want 1 4 0",
               period_valid, period_out, locked);
    end
    gap(16);
    checks++;
    if (period_valid !== 1'b1 || period_out !== 16'd16 || slow_err !== 1'b1) begin
      errors++;
      $display("FAIL rise_at_timeout: pv=%b po=%0d se=%b, want 1 16 1",
               period_valid, period_out, slow_err);
    end
  endtask

  task automatic test_tol();
    int pat [4] = '{3, 5, 3, 5};
    rst_n2 = 1'b1;
    cyc(1'b0);
    rise_edge();
    checks++;
    if (period_valid2 !== 1'b0 || locked2 !== 1'b0) begin
      errors++;
      $display("FAIL tol_first_edge: pv=%b lk=%b, want 0 0", period_valid2, locked2);
    end
    for (int i = 0; i < 4; i++) begin
      gap(pat[i]);
      checks++;
      if (period_valid2 !== 1'b1 || period_out2 !== 16'(pat[i]) || fast_err2 !== 1'b0 ||
          slow_err2 !== 1'b0 || locked2 !== (i == 3)) begin
        errors++;
        $display("FAIL tol_period%0d: pv=%b po=%0d fe=%b se=%b lk=%b, want 1 %0d 0 0 %b",
                 i, period_valid2, period_out2, fast_err2, slow_err2, locked2, pat[i], (i == 3));
      end
    end
    gap(2);
    checks++;
    if (fast_err2 !== 1'b1 || slow_err2 !== 1'b0 || locked2 !== 1'b0 || period_out2 !== 16'd2)
    begin
      errors++;
      $display("FAIL tol_fast: fe=%b se=%b lk=%b po=%0d, want 1 0 0 2",
               fast_err2, slow_err2, locked2, period_out2);
    end
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    for (int i = 0; i < 4; i++) gap(4);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL mid_prelock: lk=%b, want 1", locked);
    end
    rst_n = 1'b0;
    cyc(1'b0);
    checks++;
    if (period_out !== 16'd0 || period_valid !== 1'b0 || locked !== 1'b0 ||
        fast_err !== 1'b0 || slow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: po=%0d pv=%b lk=%b fe=%b se=%b, want all 0",
               period_out, period_valid, locked, fast_err, slow_err);
    end
    rst_n = 1'b1;
    rise_edge();
    for (int k = 1; k <= 20; k++) begin
      cyc((k % 4) == 0);
      if (period_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
`ifdef PLD_SYNC_EN
    checks++;
    if (lat !== 6 || period_out !== 16'd4) begin
      errors++;
      $display("FAIL first_pv_latency: lat=%0d po=%0d, want 6 4", lat, period_out);
    end
`else
    checks++;
    if (lat !== 4 || period_out !== 16'd4) begin
      errors++;
      $display("FAIL first_pv_latency: lat=%0d po=%0d, want 4 4", lat, period_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_lock();
    test_fast();
    test_slow();
    test_timeout();
    test_tol();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
